mc_datapath: RTL and testbench

Multicycle MIPS core: parametrised next-generation replacement for the single-cycle datapath/controller pair. One shared memory port with a req/ready handshake, an internal main-control FSM, and the architectural registers IR, MDR, A, B and ALUOut. Executes lw, sw, R-type (add, sub, and, or, slt), addi, beq and j at 3–5 cycles per instruction plus memory wait states. Sits between the top level and the unified instruction/data memory.

---
 rtl/mc_datapath.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multicycle MIPS core: main-control FSM, IR/MDR/A/B/ALUOut and one shared req/ready memory port.
// Optional feature: define MC_DATAPATH_BNE_EN to decode bne (opcode 0x05) as an inverted-compare branch.
module mc_datapath #(
    parameter logic [31:0] RESET_PC           = 32'h0000_0000,
    parameter bit          REG_ZERO_HARDWIRED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        illegal
);
    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_DATAPATH_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTEXEC, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   ir, mdr, a, b, aluout;
    logic [XLEN-1:0]   rf [32];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [XLEN-1:0]   simm, jtarget;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign simm    = {{16{ir[15]}}, ir[15:0]};
    assign jtarget = {pc[31:28], ir[25:0], 2'b00};

    logic [XLEN-1:0] rs_val_c, rt_val_c;
    assign rs_val_c = (REG_ZERO_HARDWIRED && rs == 5'd0) ? '0 : rf[rs];
    assign rt_val_c = (REG_ZERO_HARDWIRED && rt == 5'd0) ? '0 : rf[rt];

    // R-type ALU, operating on the latched A/B operands
    logic [XLEN-1:0] alu_c;
    always_comb begin
        alu_c = a + b;
        case (funct)
            FN_SUB:  alu_c = a - b;
            FN_AND:  alu_c = a & b;
            FN_OR:   alu_c = a | b;
            FN_SLT:  alu_c = {31'd0, ($signed(a) < $signed(b))};
            default: alu_c = a + b;
        endcase
    end

    // Opcode/funct decode: next state after DECODE, or unsupported
    state_t dec_next_c;
    logic   dec_ok_c;
    always_comb begin
        dec_ok_c   = 1'b1;
        dec_next_c = FETCH;
        case (op)
            OP_LW, OP_SW: dec_next_c = MEMADR;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dec_next_c = RTEXEC;
                    default: dec_ok_c = 1'b0;
                endcase
            end
            OP_ADDI: dec_next_c = ADDIEX;
            OP_BEQ:  dec_next_c = BRANCH;
`ifdef MC_DATAPATH_BNE_EN
            OP_BNE:  dec_next_c = BRANCH;
`endif
            OP_J:    dec_next_c = JUMP;
            default: dec_ok_c = 1'b0;
        endcase
    end

    logic taken_c;
`ifdef MC_DATAPATH_BNE_EN
    assign taken_c = (op == OP_BNE) ? (a != b) : (a == b);
`else
    assign taken_c = (a == b);
`endif

    // Register-file write port; only the writeback states write
    logic            rf_we_c;
    logic [4:0]      rf_waddr_c;
    logic [XLEN-1:0] rf_wdata_c;
    always_comb begin
        rf_we_c    = 1'b0;
        rf_waddr_c = rt;
        rf_wdata_c = aluout;
        case (state)
            MEMWB: begin
                rf_we_c    = 1'b1;
                rf_wdata_c = mdr;
            end
            RTWB: begin
                rf_we_c    = 1'b1;
                rf_waddr_c = rd;
            end
            ADDIWB:  rf_we_c = 1'b1;
            default: rf_we_c = 1'b0;
        endcase
        if (REG_ZERO_HARDWIRED && rf_waddr_c == 5'd0) rf_we_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rf_we_c) rf[rf_waddr_c] <= rf_wdata_c;
    end

    // Main control: every transition into FETCH launches the next instruction fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            mdr       <= '0;
            a         <= '0;
            b         <= '0;
            aluout    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                DECODE: begin
                    a      <= rs_val_c;
                    b      <= rt_val_c;
                    aluout <= pc + (simm << 2);
                    state  <= dec_next_c;
                    if (!dec_ok_c) begin
                        illegal  <= 1'b1;
                        retire   <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                MEMADR: begin
                    aluout   <= a + simm;
                    mem_req  <= 1'b1;
                    mem_addr <= a + simm;
                    if (op == OP_LW) begin
                        mem_we <= 1'b0;
                        state  <= MEMRD;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= b;
                        state     <= MEMWR;
                    end
                end
                MEMRD: begin
                    if (mem_req && mem_ready) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= MEMWB;
                    end
                end
                MEMWR: begin
                    if (mem_req && mem_ready) begin
                        retire   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= FETCH;
                    end
                end
                RTEXEC: begin
                    aluout <= alu_c;
                    state  <= RTWB;
                end
                ADDIEX: begin
                    aluout <= a + simm;
                    state  <= ADDIWB;
                end
                MEMWB, RTWB, ADDIWB: begin
                    retire   <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    state    <= FETCH;
                end
                BRANCH: begin
                    retire   <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= taken_c ? aluout : pc;
                    if (taken_c) pc <= aluout;
                    state    <= FETCH;
                end
                JUMP: begin
                    retire   <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= jtarget;
                    pc       <= jtarget;
                    state    <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: a directed prelude plus a random forward-only program, checked
// instruction by instruction against an ISA-level interpreter; ends with a reset abort during a store wait.
`timescale 1ns/1ps
module tb_mc_datapath;
    localparam int unsigned MEM_WORDS = 256;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] END_PC    = 32'h0000_01E0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        retire, illegal;

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(RESET_PC), .REG_ZERO_HARDWIRED(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .illegal(illegal)
    );

    logic [31:0] mem [MEM_WORDS];
    assign mem_rdata = mem[mem_addr[9:2]];

    // 0: always ready, 1: random wait states, 2: stall every write forever
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 3) != 0);
            default: mem_ready = !mem_we;
        endcase
    end

    int unsigned st_count = 0;
    logic [31:0] st_addr = '0, st_data = '0;
    always @(posedge clk) begin
        if (reset && mem_req && mem_we && mem_ready) begin
            st_count++;
            st_addr = mem_addr;
            st_data = mem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (architectural state) ----------------
    logic [31:0] mreg [32];
    logic [31:0] mmem [MEM_WORDS];
    logic [31:0] mpc;
    bit          mill;
    int          m_cycles;
    bit          m_store;
    logic [31:0] m_st_addr, m_st_data;

    task automatic mwrite(input logic [4:0] idx, input logic [31:0] val);
        if (idx != 5'd0) mreg[idx] = val;
    endtask

    task automatic model_step();
        logic [31:0] w, va, vb, simm, npc, ea;
        w    = mmem[mpc[9:2]];
        va   = mreg[w[25:21]];
        vb   = mreg[w[20:16]];
        simm = {{16{w[15]}}, w[15:0]};
        npc  = mpc + 32'd4;
        ea   = va + simm;
        m_store = 1'b0;
        case (w[31:26])
            6'h23: begin mwrite(w[20:16], mmem[ea[9:2]]); m_cycles = 5; end
            6'h2B: begin
                m_store = 1'b1; m_st_addr = ea; m_st_data = vb;
                mmem[ea[9:2]] = vb; m_cycles = 4;
            end
            6'h08: begin mwrite(w[20:16], ea); m_cycles = 4; end
            6'h00: begin
                m_cycles = 4;
                case (w[5:0])
                    6'h20: mwrite(w[15:11], va + vb);
                    6'h22: mwrite(w[15:11], va - vb);
                    6'h24: mwrite(w[15:11], va & vb);
                    6'h25: mwrite(w[15:11], va | vb);
                    6'h2A: mwrite(w[15:11], ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0);
                    default: begin mill = 1'b1; m_cycles = 2; end
                endcase
            end
            6'h04: begin if (va == vb) npc = npc + (simm << 2); m_cycles = 3; end
`ifdef MC_DATAPATH_BNE_EN
            6'h05: begin if (va != vb) npc = npc + (simm << 2); m_cycles = 3; end
`endif
            6'h02: begin npc = {npc[31:28], w[25:0], 2'b00}; m_cycles = 3; end
            default: begin mill = 1'b1; m_cycles = 2; end
        endcase
        mpc = npc;
    endtask

    // ---------------- program construction ----------------
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_j(input int target_word);
        return {6'h02, 26'(target_word)};
    endfunction

    task automatic put(input int idx, input logic [31:0] w);
        mem[idx]  = w;
        mmem[idx] = w;
    endtask

    task automatic build_program();
        int r, off, dt, src;
        int fns [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int bad [4] = '{32'h3F, 32'h01, 32'h0F, 32'h10};
        for (int i = 0; i < MEM_WORDS; i++) put(i, (i >= 128) ? $urandom : 32'd0);
        put(0,  enc_i(8, 0, 9, 5));
        put(1,  enc_i(8, 0, 10, 7));
        put(2,  enc_i(8, 0, 11, 9));
        put(3,  enc_r(10, 11, 9, 32'h20));
        put(4,  enc_i(8, 0, 10, -1));
        put(5,  enc_i(8, 0, 11, 1));
        put(6,  enc_r(10, 11, 9, 32'h2A));
        put(7,  enc_i(8, 0, 8, 32'h200));
        put(8,  enc_i(4, 0, 0, 1));
        put(9,  32'hFC00_0000);
        put(10, enc_i(4, 10, 11, 1));
        put(11, enc_j(13));
        put(12, 32'hFC00_0000);
        put(13, enc_i(32'h2B, 8, 9, 4));
        put(14, enc_i(32'h23, 8, 12, 4));
        put(15, enc_i(5, 10, 11, 1));
        put(16, enc_i(8, 0, 13, 3));
        put(17, 32'hFC00_0000);
        for (int k = 1; k <= 7; k++) put(17 + k, enc_i(8, 0, k, $urandom));
        for (int w = 25; w < 120; w++) begin
            r   = $urandom_range(0, 99);
            dt  = $urandom_range(0, 7);
            src = $urandom_range(0, 8);
            off = $urandom_range(0, 63) * 4;
            if (r < 25)      put(w, enc_i(8, src, dt, $urandom));
            else if (r < 50) put(w, enc_r(src, $urandom_range(0, 8), dt,
                                          ($urandom_range(0, 11) == 0) ? 32'h21 : fns[$urandom_range(0, 4)]));
            else if (r < 62) put(w, enc_i(32'h23, 8, dt, off));
            else if (r < 72) put(w, enc_i(32'h2B, 8, src, off));
            else if (r < 88) begin
                off = $urandom_range(0, 3);
                if (off > 119 - w) off = 119 - w;
                put(w, enc_i((r < 82) ? 4 : 5, src, $urandom_range(0, 8), off));
            end else if (r < 94) begin
                off = w + $urandom_range(1, 4);
                put(w, enc_j((off > 120) ? 120 : off));
            end else put(w, {6'(bad[$urandom_range(0, 3)]), 26'($urandom)});
        end
        put(120, enc_i(32'h2B, 8, 1, 0));
        put(121, enc_i(4, 0, 0, -2));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          cnt, stalls, nret;
        int unsigned st_applied, st_at_ret;
        bit          done;
        logic [31:0] held_word;

        build_program();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mpc = RESET_PC; mill = 1'b0;
        cnt = 0; stalls = 0; nret = 0; st_applied = 0; st_at_ret = 0; done = 1'b0;

        repeat (3) @(negedge clk);
        check32("reset_mem_req", 32'(mem_req), 32'd0);
        check32("reset_mem_we",  32'(mem_we),  32'd0);
        check32("reset_retire",  32'(retire),  32'd0);
        check32("reset_illegal", 32'(illegal), 32'd0);
        check32("reset_pc",      pc,           RESET_PC);
        reset = 1'b1;

        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check32("first_req",  32'(mem_req), 32'd1);
                check32("first_addr", mem_addr,     RESET_PC);
            end
            if (cyc == 60) ready_mode = 1;
            if (st_count != st_applied) begin
                mem[st_addr[9:2]] = st_data;
                st_applied = st_count;
            end
            if (retire) begin
                model_step();
                nret++;
                check32($sformatf("pc_ret%0d", nret), pc, mpc);
                check32($sformatf("illegal_ret%0d", nret), 32'(illegal), 32'(mill));
                check32($sformatf("cycles_ret%0d", nret), 32'(cnt), 32'(m_cycles + stalls));
                check32($sformatf("stores_ret%0d", nret), st_count - st_at_ret, 32'(m_store));
                if (m_store) begin
                    check32($sformatf("st_addr_ret%0d", nret), st_addr, m_st_addr);
                    check32($sformatf("st_data_ret%0d", nret), st_data, m_st_data);
                end
                case (nret)
                    1:  begin check32("addi_pc", pc, 32'h4); check32("addi_r9", dut.rf[9], 32'd5); end
                    4:  check32("add_r9", dut.rf[9], 32'h10);
                    7:  check32("slt_r9", dut.rf[9], 32'd1);
                    9:  check32("beq_taken_pc", pc, 32'h28);
                    10: check32("beq_nottaken_pc", pc, 32'h2C);
                    11: check32("j_pc", pc, 32'h34);
                    13: check32("lw_r12", dut.rf[12], 32'd1);
`ifdef MC_DATAPATH_BNE_EN
                    14: begin check32("bne_pc", pc, 32'h44); check32("bne_illegal", 32'(illegal), 32'd0); end
`else
                    14: begin check32("bne_pc", pc, 32'h40); check32("bne_illegal", 32'(illegal), 32'd1); end
`endif
                    default: ;
                endcase
                cnt = 0; stalls = 0; st_at_ret = st_count;
                if (nret > 20 && mpc == END_PC) done = 1'b1;
            end
            cnt++;
            if (mem_req && !mem_ready) stalls++;
        end
        check32("reach_end", 32'(done), 32'd1);

        // Abort a store that is stuck waiting for mem_ready
        ready_mode = 2;
        done = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            @(negedge clk);
            done = mem_req && mem_we;
        end
        check32("store_wait_seen", 32'(done), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check32("wait_addr_held",  mem_addr,  32'h200);
            check32("wait_wdata_held", mem_wdata, mreg[1]);
            check32("wait_req_held",   32'({mem_req, mem_we}), 32'd3);
        end
        held_word  = mem[128];
        st_applied = st_count;
        #1 reset = 1'b0;
        #1;
        check32("abort_mem_req", 32'(mem_req), 32'd0);
        check32("abort_mem_we",  32'(mem_we),  32'd0);
        check32("abort_pc",      pc,           RESET_PC);
        check32("abort_retire",  32'(retire),  32'd0);
        repeat (2) @(negedge clk);
        check32("abort_no_store", st_count, st_applied);
        check32("abort_mem_word", mem[128], held_word);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
